// File: rtl/seg7_pkg.sv
// seg7_pkg: shared definitions for the seven-segment scan driver.
//   - HEX_SEG_TABLE : active-high segment patterns for hex digits 0..F,
//                     bit 6 = segment A ... bit 0 = segment G.
//   - SEG_A..SEG_G  : bit positions of each segment in a 7-bit pattern.
//   - scan_state_t  : per-slot scan phase (guard interval or drive).
//   - idx_width()   : index width helper, $clog2(n) but never below 1.
package seg7_pkg;

  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;

  localparam logic [6:0] HEX_SEG_TABLE [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  typedef enum logic {
    SCAN_GUARD = 1'b0,
    SCAN_DRIVE = 1'b1
  } scan_state_t;

  // A 1-entry space still needs a 1-bit index to keep declarations legal.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// hex_to_seg7: combinational hex nibble to seven-segment decoder.
// Ports:
//   nibble : in  [3:0]  hex digit
//   seg    : out [6:0]  active-high pattern, bit 6 = A ... bit 0 = G
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_SEG_TABLE[nibble];

endmodule

// File: rtl/sevenseg_scan_driver.sv
// sevenseg_scan_driver: time-multiplexed N-digit hexadecimal display driver.
// A loaded value is held in a shadow register and only copied to the
// display register when the scan wraps from the last digit to digit 0,
// so a frame never mixes old and new digits. Each digit slot starts with
// a guard interval (all anodes and segments off) to avoid ghosting.
//
// Ports:
//   i_Clk      : in   system clock
//   i_Rst_n    : in   asynchronous active-low reset
//   i_value    : in   [4*NUM_DIGITS-1:0] packed nibbles, digit 0 in bits [3:0]
//   i_load     : in   single-cycle capture request for i_value
//   i_blank_lz : in   1 = blank leading-zero digits (digit 0 never blanked)
//   o_pending  : out  a captured value waits for the frame boundary
//   o_seg      : out  [6:0] segments, bit 6 = A ... bit 0 = G
//   o_an       : out  [NUM_DIGITS-1:0] one-hot digit enable
//
// Optional build macro SEVENSEG_DP_EN adds decimal-point support:
//   i_dp       : in   [NUM_DIGITS-1:0] dp bit per digit, captured with i_value
//   o_dp       : out  dp pin, same polarity as the segment pins
module sevenseg_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 25000,
  parameter int GUARD_CYCLES   = 2,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst_n,
  input  logic [4*NUM_DIGITS-1:0] i_value,
  input  logic                    i_load,
  input  logic                    i_blank_lz,
`ifdef SEVENSEG_DP_EN
  input  logic [NUM_DIGITS-1:0]   i_dp,
  output logic                    o_dp,
`endif
  output logic                    o_pending,
  output logic [6:0]              o_seg,
  output logic [NUM_DIGITS-1:0]   o_an
);

  localparam int DW = 4 * NUM_DIGITS;
  localparam int IW = idx_width(NUM_DIGITS);
  localparam int CW = idx_width(REFRESH_DIV);

  localparam logic [CW-1:0] LAST_CNT = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);

  // XOR masks that convert active-high internal values to pin polarity;
  // the same mask applied to zero gives the "off" level.
  localparam logic [6:0]            SEG_INV = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [NUM_DIGITS-1:0] AN_INV  = (AN_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}}
                                                                   : {NUM_DIGITS{1'b0}};

  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic [DW-1:0]         shadow;
  logic [DW-1:0]         disp;
  logic                  pending;

  logic                  slot_end;
  logic                  frame_end;
  logic                  in_guard;
  scan_state_t           state;
  logic [3:0]            nibble [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] blank_mask;
  logic [NUM_DIGITS-1:0] dp_keep;
  logic [NUM_DIGITS-1:0] onehot;
  logic [6:0]            cur_pattern;
  logic                  cur_blank;

`ifdef SEVENSEG_DP_EN
  localparam logic DP_INV = (SEG_ACTIVE_LOW != 0);
  logic [NUM_DIGITS-1:0] dp_shadow;
  logic [NUM_DIGITS-1:0] dp_disp;
  assign dp_keep = dp_disp;
`else
  assign dp_keep = '0;
`endif

  assign slot_end  = (cnt == LAST_CNT);
  assign frame_end = slot_end && (idx == LAST_IDX);

  generate
    if (GUARD_CYCLES > 0) begin : g_guard
      assign in_guard = (cnt < CW'(GUARD_CYCLES));
    end else begin : g_no_guard
      assign in_guard = 1'b0;
    end
  endgenerate

  assign state = in_guard ? SCAN_GUARD : SCAN_DRIVE;

  // A digit is a leading zero when it and every more-significant nibble
  // are zero; each mask bit compares its own upper slice directly.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign nibble[gi] = disp[4*gi +: 4];
      if (gi == 0) begin : g_lsd
        assign blank_mask[gi] = 1'b0;
      end else begin : g_upper
        assign blank_mask[gi] = i_blank_lz && (disp[DW-1:4*gi] == '0);
      end
    end
  endgenerate

  // A set decimal point keeps its digit visible.
  assign cur_blank = blank_mask[idx] && !dp_keep[idx];
  assign onehot    = NUM_DIGITS'(1) << idx;

  hex_to_seg7 u_dec (
    .nibble (nibble[idx]),
    .seg    (cur_pattern)
  );

  assign o_pending = pending;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      cnt     <= '0;
      idx     <= '0;
      shadow  <= '0;
      disp    <= '0;
      pending <= 1'b0;
      o_seg   <= SEG_INV;
      o_an    <= AN_INV;
`ifdef SEVENSEG_DP_EN
      dp_shadow <= '0;
      dp_disp   <= '0;
      o_dp      <= DP_INV;
`endif
    end else begin
      if (slot_end) begin
        cnt <= '0;
        idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end

      // Commit first, then capture: a load on the boundary edge commits
      // the older shadow and leaves the new value pending.
      if (frame_end && pending) begin
        disp    <= shadow;
        pending <= 1'b0;
`ifdef SEVENSEG_DP_EN
        dp_disp <= dp_shadow;
`endif
      end
      if (i_load) begin
        shadow  <= i_value;
        pending <= 1'b1;
`ifdef SEVENSEG_DP_EN
        dp_shadow <= i_dp;
`endif
      end

      if (state == SCAN_GUARD) begin
        o_seg <= SEG_INV;
        o_an  <= AN_INV;
`ifdef SEVENSEG_DP_EN
        o_dp  <= DP_INV;
`endif
      end else begin
        o_seg <= (cur_blank ? 7'h00 : cur_pattern) ^ SEG_INV;
        o_an  <= onehot ^ AN_INV;
`ifdef SEVENSEG_DP_EN
        o_dp  <= dp_disp[idx] ^ DP_INV;
`endif
      end
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Testbench for sevenseg_scan_driver (4 digits, 8-cycle slots, 1 guard cycle,
// active-low pins). A behavioural model tracks cycles since reset release
// and derives slot/digit from plain division, checked on every cycle.
module tb_sevenseg_scan_driver;

  localparam int ND = 4;
  localparam int RD = 8;
  localparam int GC = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value = '0;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic        pending;
  logic [6:0]  seg;
  logic [3:0]  an;
`ifdef SEVENSEG_DP_EN
  logic [3:0]  dp_in = '0;
  logic        dp_out;
`endif

  always #5 clk = ~clk;

  sevenseg_scan_driver #(
    .NUM_DIGITS     (ND),
    .REFRESH_DIV    (RD),
    .GUARD_CYCLES   (GC),
    .SEG_ACTIVE_LOW (1),
    .AN_ACTIVE_LOW  (1)
  ) dut (
    .i_Clk      (clk),
    .i_Rst_n    (rst_n),
    .i_value    (value),
    .i_load     (load),
    .i_blank_lz (blank_lz),
`ifdef SEVENSEG_DP_EN
    .i_dp       (dp_in),
    .o_dp       (dp_out),
`endif
    .o_pending  (pending),
    .o_seg      (seg),
    .o_an       (an)
  );

  int errors = 0;
  int checks = 0;

  logic [6:0] pat [16];
  logic [3:0] an_sel [4];

  // Reference model state
  int          n;
  int          last_n;
  logic [15:0] m_disp;
  logic [15:0] m_shadow;
  logic        m_pend;
  logic [6:0]  e_seg;
  logic [3:0]  e_an;
  logic        e_pend;

  typedef struct {
    logic [15:0] value;
    logic        blz;
    logic [27:0] exp;  // {digit3, digit2, digit1, digit0} pin patterns
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    n = 0;
    m_disp = '0;
    m_shadow = '0;
    m_pend = 1'b0;
    e_seg = 7'h7F;
    e_an = 4'hF;
    e_pend = 1'b0;
  endtask

  // Expected pins after an edge come from the state before it.
  task automatic model_step(input logic ld, input logic [15:0] v, input logic blz);
    int pos;
    int dig;
    logic [3:0] nib;
    logic blank;
    pos = n % RD;
    dig = (n / RD) % ND;
    if (pos < GC) begin
      e_seg = 7'h7F;
      e_an = 4'hF;
    end else begin
      nib = m_disp[4*dig +: 4];
      blank = blz && (dig != 0) && ((m_disp >> (4*dig)) == 16'h0);
      e_an = ~(4'b0001 << dig);
      e_seg = blank ? 7'h7F : ~pat[nib];
    end
    if (pos == RD-1 && dig == ND-1 && m_pend) begin
      m_disp = m_shadow;
      m_pend = 1'b0;
    end
    if (ld) begin
      m_shadow = v;
      m_pend = 1'b1;
    end
    e_pend = m_pend;
    last_n = n;
    n++;
  endtask

  // Called in the negedge phase; drives inputs, clocks once, checks.
  task automatic tick(input logic ld, input logic [15:0] v);
    load = ld;
    value = v;
    @(posedge clk);
    model_step(ld, v, blank_lz);
    @(negedge clk);
    load = 1'b0;
    chk("seg", {25'd0, seg}, {25'd0, e_seg});
    chk("an", {28'd0, an}, {28'd0, e_an});
    chk("pending", {31'd0, pending}, {31'd0, e_pend});
  endtask

  task automatic run_to_frame_start();
    int guard;
    guard = 0;
    while ((n % (RD*ND)) != 0) begin
      tick(1'b0, value);
      guard++;
      if (guard > 2*RD*ND) begin
        chk("frame_start_timeout", 32'd1, 32'd0);
        return;
      end
    end
  endtask

  task automatic wait_commit();
    int guard;
    guard = 0;
    while (pending === 1'b1) begin
      tick(1'b0, value);
      guard++;
      if (guard > 3*RD*ND) begin
        chk("commit_timeout", 32'd1, 32'd0);
        return;
      end
    end
  endtask

  task automatic check_frame(input string name, input logic [27:0] exp);
    run_to_frame_start();
    for (int k = 0; k < RD*ND; k++) begin
      tick(1'b0, value);
      if ((k % RD) == 4) begin
        chk({name, "_seg"}, {25'd0, seg}, {25'd0, exp[7*(k/RD) +: 7]});
        chk({name, "_an"}, {28'd0, an}, {28'd0, an_sel[k/RD]});
      end
    end
    $display("frame %s: expected %07h", name, exp);
  endtask

  initial begin
    #1ms;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int guard;
    logic ld;

    pat[0]  = 7'h7E; pat[1]  = 7'h30; pat[2]  = 7'h6D; pat[3]  = 7'h79;
    pat[4]  = 7'h33; pat[5]  = 7'h5B; pat[6]  = 7'h5F; pat[7]  = 7'h70;
    pat[8]  = 7'h7F; pat[9]  = 7'h7B; pat[10] = 7'h77; pat[11] = 7'h1F;
    pat[12] = 7'h4E; pat[13] = 7'h3D; pat[14] = 7'h4F; pat[15] = 7'h47;
    an_sel[0] = 4'hE; an_sel[1] = 4'hD; an_sel[2] = 4'hB; an_sel[3] = 4'h7;

    vecs[0] = '{16'h12AF, 1'b0, {7'h4F, 7'h12, 7'h08, 7'h38}};
    vecs[1] = '{16'h0005, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h24}};
    vecs[2] = '{16'h0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h01}};
    vecs[3] = '{16'h0F00, 1'b1, {7'h7F, 7'h38, 7'h01, 7'h01}};
    vecs[4] = '{16'h8000, 1'b1, {7'h00, 7'h01, 7'h01, 7'h01}};
    vecs[5] = '{16'h0000, 1'b0, {7'h01, 7'h01, 7'h01, 7'h01}};
    vecs[6] = '{16'h3C07, 1'b0, {7'h06, 7'h31, 7'h01, 7'h0F}};

    model_reset();

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_seg", {25'd0, seg}, 32'h7F);
    chk("rst_an", {28'd0, an}, 32'hF);
    chk("rst_pending", {31'd0, pending}, 32'd0);
    rst_n = 1'b1;

    // First slot: guard cycle, then digit 0 showing '0'
    tick(1'b0, 16'h0);
    chk("t1_guard_seg", {25'd0, seg}, 32'h7F);
    chk("t1_guard_an", {28'd0, an}, 32'hF);
    tick(1'b0, 16'h0);
    chk("t1_d0_seg", {25'd0, seg}, 32'h01);
    chk("t1_d0_an", {28'd0, an}, 32'hE);

    // Table-driven display vectors
    for (int i = 0; i < 7; i++) begin
      blank_lz = vecs[i].blz;
      tick(1'b1, vecs[i].value);
      chk("vec_pending_set", {31'd0, pending}, 32'd1);
      wait_commit();
      check_frame($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Two loads in one frame: last one wins
    blank_lz = 1'b0;
    run_to_frame_start();
    tick(1'b1, 16'h1111);
    repeat (3) tick(1'b0, value);
    tick(1'b1, 16'h2222);
    wait_commit();
    check_frame("t3_last_wins", {7'h12, 7'h12, 7'h12, 7'h12});

    // Load on the exact wrap edge while a value is pending
    run_to_frame_start();
    tick(1'b1, 16'h000F);
    guard = 0;
    while ((n % (RD*ND)) != RD*ND-1 && guard < 2*RD*ND) begin
      tick(1'b0, value);
      guard++;
    end
    chk("t4_reach_wrap", {31'd0, ((n % (RD*ND)) == RD*ND-1)}, 32'd1);
    tick(1'b1, 16'h0F00);
    chk("t4_pend_stays", {31'd0, pending}, 32'd1);
    check_frame("t4_first", {7'h01, 7'h01, 7'h01, 7'h38});
    chk("t4_pend_clr", {31'd0, pending}, 32'd0);
    check_frame("t4_second", {7'h01, 7'h38, 7'h01, 7'h01});

    // Async reset mid-DRIVE with a pending load
    tick(1'b1, 16'hABCD);
    guard = 0;
    while ((n % RD) != 4 && guard < 2*RD) begin
      tick(1'b0, value);
      guard++;
    end
    chk("t6_pend_before", {31'd0, pending}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_seg", {25'd0, seg}, 32'h7F);
    chk("t6_rst_an", {28'd0, an}, 32'hF);
    chk("t6_rst_pending", {31'd0, pending}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    check_frame("t6_after", {7'h01, 7'h01, 7'h01, 7'h01});
    chk("t6_pend_after", {31'd0, pending}, 32'd0);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if ((c % 50) == 0) blank_lz = 1'($urandom_range(0, 1));
      ld = ($urandom_range(0, 15) == 0);
      tick(ld, 16'($urandom));
    end
    $display("random phase: 3000 cycles, errors so far %0d", errors);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sevenseg_scan_driver.md
Name: sevenseg_scan_driver

Overview:
Parametrised, time-multiplexed N-digit hexadecimal seven-segment driver. It supersedes the fixed two-digit combinational decoder.
- Accepts a packed nibble vector through a load handshake.
- Scans one digit at a time with a programmable refresh divider and an anti-ghosting guard interval.
- Updates the displayed value only at frame boundaries, so a load never produces a torn display.
- Sits between the synthesizer control logic and the board's segment/anode pins.

Parameters:
NUM_DIGITS, 4, digit count (1..8); input width = 4*NUM_DIGITS.
REFRESH_DIV, 25000, clock cycles per digit slot (>= GUARD_CYCLES+2).
GUARD_CYCLES, 2, cycles at slot start with all anodes off (0 disables guard).
SEG_ACTIVE_LOW, 1, 1 = segment pins lit on 0; 0 = lit on 1.
AN_ACTIVE_LOW, 1, 1 = anode enables active on 0.

Ports:
i_Clk  in  1  system clock
i_Rst_n  in  1  asynchronous, active-low reset
i_value  in  4*NUM_DIGITS  packed nibbles; digit k = i_value[4k+3:4k], digit 0 least significant
i_load  in  1  single-cycle request to capture i_value
i_blank_lz  in  1  1 = blank leading-zero digits
o_pending  out  1  captured value waiting for frame boundary
o_seg  out  7  segments; bit6 = A ... bit0 = G
o_an  out  NUM_DIGITS  one-hot digit enable

Behaviour:
- Clock and reset: one clock, i_Clk. Reset is i_Rst_n, asynchronous and active-low.
- Reset values:
  - Divider count, digit index, shadow register, display register and o_pending = 0.
  - o_seg = all segments off (7'h7F if SEG_ACTIVE_LOW, else 7'h00).
  - o_an = all digits off.
- Decoder patterns (active-high, A..G), 0-F: 7E 30 6D 79 33 5B 5F 70 7F 7B 77 1F 4E 3D 4F 47.
  - Output is inverted when SEG_ACTIVE_LOW.
- Divider: cnt counts 0..REFRESH_DIV-1. At cnt == REFRESH_DIV-1, cnt returns to 0 and the digit index advances.
  - The index wraps from NUM_DIGITS-1 to 0; that wrap is the frame boundary.
- Load handshake:
  - i_load high captures i_value into the shadow register and sets o_pending the next cycle.
  - Further loads while pending overwrite the shadow (last wins).
  - At the frame boundary with o_pending = 1, the shadow is copied to the display register and o_pending clears in the same edge.
  - i_load coincident with the frame boundary: the new i_value is captured into the shadow and o_pending stays 1. The previous shadow is committed.
- Scan states, per slot:
  - GUARD: cnt < GUARD_CYCLES; o_an all off, o_seg all off.
  - DRIVE: remainder of the slot; o_an enables the current index, o_seg shows its pattern.
- All outputs are registered; latency is 1 cycle from the cnt/index update to the pins.
- Leading-zero blanking: with i_blank_lz = 1, digit k is blanked (segments off, anode still driven) when every display nibble from k up to NUM_DIGITS-1 is zero.
  - Digit 0 is never blanked.
  - i_blank_lz is sampled live, per slot.
- Reset asserted mid-frame: all state clears immediately and asynchronously; any pending load is discarded.
- NUM_DIGITS = 1: every slot end is a frame boundary.

Optional Feature:
Macro SEVENSEG_DP_EN.
- Defined: adds input i_dp [NUM_DIGITS-1:0] and output o_dp [1].
  - i_dp is captured with i_value on i_load and committed at the same frame boundary.
  - o_dp drives the current digit's bit during DRIVE and is off during GUARD and reset.
  - o_dp uses SEG_ACTIVE_LOW polarity.
  - Leading-zero blanking does not blank a digit whose dp bit is set.
- Undefined: no i_dp/o_dp ports and no dp storage.

Decomposition:
- Package seg7_pkg holds:
  - the 16-entry hex-to-segment constant table;
  - segment bit-index constants A..G;
  - localparam helper for the index width, $clog2(NUM_DIGITS), min 1.
- Sub-module hex_to_seg7: combinational nibble-to-7-bit active-high decoder, instantiated once on the muxed nibble.

Test Plan:
All scenarios use NUM_DIGITS=4, REFRESH_DIV=8, GUARD_CYCLES=1, both polarities active-low.
1. Reset: hold i_Rst_n=0 -> o_seg=7'h7F, o_an=4'hF, o_pending=0. Release -> first slot shows digit 0 = 7'h01 on o_an=4'hE after the guard cycle.
2. Load 16'h12AF, then wait one frame -> o_pending high until the wrap. Next frame slots show 7'h38 (F), 7'h08 (A), 7'h12 (2), 7'h4F (1) on an E, D, B, 7.
3. Two loads in one frame (16'h1111, then 16'h2222) -> after the boundary every digit shows 7'h12. 16'h1111 is never displayed.
4. i_load on the exact wrap cycle with 16'h000F pending and 16'h0F00 presented -> 000F displayed for one frame, o_pending stays 1, 0F00 displays the following frame.
5. i_blank_lz=1 with 16'h0005 -> digits 3..1 show 7'h7F with anodes active; digit 0 shows 7'h24. Value 16'h0000 -> digit 0 shows 7'h01.
6. Assert i_Rst_n low mid-DRIVE with a load pending -> outputs blank in the same cycle (async). After release, the display shows 0000 and o_pending=0.
